// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and write-encoding constants for the memory-port arbiter.
// Rev 1.0
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic [1:0] WE_RD  = 2'b00;
  localparam logic [1:0] WE_W32 = 2'b01;
  localparam logic [1:0] WE_WN  = 2'b11;

  // The unused 2'b10 code is folded onto a full-width write.
  function automatic logic [1:0] norm_we(input logic [1:0] we);
    return (we == 2'b10) ? WE_WN : we;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_if.sv
// mem_arb_if: fetch, data and memory-port signals of the arbiter; master = arbiter view.
// Rev 1.0
`default_nettype none

interface mem_arb_if #(
  parameter int N = 64
);
  logic          i_req;
  logic [31:0]   i_adr;
  logic          i_abort;
  logic [31:0]   i_rdata;
  logic          i_val;

  logic          d_req;
  logic [1:0]    d_we;
  logic [N-1:0]  d_adr;
  logic [N-1:0]  d_wdata;
  logic [N-1:0]  d_rdata;
  logic          d_val;

  logic          m_req;
  logic [1:0]    m_we;
  logic [N-1:0]  m_adr;
  logic [N-1:0]  m_wdata;
  logic [N-1:0]  m_rdata;
  logic          m_ack;

  modport master (
    input  i_req, i_adr, i_abort, d_req, d_we, d_adr, d_wdata, m_rdata, m_ack,
    output i_rdata, i_val, d_rdata, d_val, m_req, m_we, m_adr, m_wdata
  );

  modport slave (
    output i_req, i_adr, i_abort, d_req, d_we, d_adr, d_wdata, m_rdata, m_ack,
    input  i_rdata, i_val, d_rdata, d_val, m_req, m_we, m_adr, m_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_arb_perf.sv
// mem_arb_perf: wrapping 32-bit grant and fetch-stall event counters for mem_arbiter.
// Rev 1.0
`default_nettype none

module mem_arb_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        igrant_i,
  input  logic        dgrant_i,
  input  logic        istall_i,
  output logic [31:0] igrant_o,
  output logic [31:0] dgrant_o,
  output logic [31:0] istall_o
);
  logic [31:0] igrant_q, dgrant_q, istall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      igrant_q <= 32'd0;
      dgrant_q <= 32'd0;
      istall_q <= 32'd0;
    end else begin
      if (igrant_i) igrant_q <= igrant_q + 32'd1;
      if (dgrant_i) dgrant_q <= dgrant_q + 32'd1;
      if (istall_i) istall_q <= istall_q + 32'd1;
    end
  end

  assign igrant_o = igrant_q;
  assign dgrant_o = dgrant_q;
  assign istall_o = istall_q;
endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data sides, data-priority with a fetch
// starvation guard. MEM_ARB_PERF_EN adds perf_igrant/perf_dgrant/perf_istall counters. Rev 1.0
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N          = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  mem_arb_if.master   bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_igrant,
  output logic [31:0] perf_dgrant,
  output logic [31:0] perf_istall
`endif
);
  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          aborted_q, aborted_d;
  logic          m_req_q, m_req_d;
  logic [1:0]    m_we_q, m_we_d;
  logic [N-1:0]  m_adr_q, m_adr_d;
  logic [N-1:0]  m_wdata_q, m_wdata_d;
  logic [N-1:0]  d_rdata_q, d_rdata_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic          i_val_q, i_val_d;
  logic          d_val_q, d_val_d;

  logic          i_live;
  logic          grant_i;
  logic          grant_d;

  // A fetch raised together with its own abort never competes.
  assign i_live  = bus.i_req & ~bus.i_abort;
  assign grant_d = (state_q == IDLE) & bus.d_req & ~(i_live & (starve_q >= STARVE_LIM));
  assign grant_i = (state_q == IDLE) & i_live & ~grant_d;

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    aborted_d = aborted_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_adr_d   = m_adr_q;
    m_wdata_d = m_wdata_q;
    d_rdata_d = d_rdata_q;
    i_rdata_d = i_rdata_q;
    i_val_d   = 1'b0;
    d_val_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d   = BUSY_D;
          m_req_d   = 1'b1;
          m_we_d    = norm_we(bus.d_we);
          m_adr_d   = bus.d_adr;
          m_wdata_d = bus.d_wdata;
          if (bus.i_req && (starve_q < STARVE_LIM)) starve_d = starve_q + SW'(1);
        end else if (grant_i) begin
          state_d   = BUSY_I;
          starve_d  = '0;
          aborted_d = 1'b0;
          m_req_d   = 1'b1;
          m_we_d    = WE_RD;
          m_adr_d   = {{(N-32){1'b0}}, bus.i_adr};
          m_wdata_d = '0;
        end
      end
      BUSY_I: begin
        if (bus.i_abort) aborted_d = 1'b1;
        if (bus.m_ack) begin
          state_d = RESP;
          m_req_d = 1'b0;
          if (!aborted_q && !bus.i_abort) begin
            i_val_d   = 1'b1;
            i_rdata_d = m_adr_q[2] ? bus.m_rdata[63:32] : bus.m_rdata[31:0];
          end
        end
      end
      BUSY_D: begin
        if (bus.m_ack) begin
          state_d = RESP;
          m_req_d = 1'b0;
          d_val_d = 1'b1;
          if (m_we_q == WE_RD) d_rdata_d = bus.m_rdata;
        end
      end
      RESP: begin
        state_d   = IDLE;
        aborted_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      aborted_q <= 1'b0;
      m_req_q   <= 1'b0;
      m_we_q    <= WE_RD;
      m_adr_q   <= '0;
      m_wdata_q <= '0;
      d_rdata_q <= '0;
      i_rdata_q <= 32'd0;
      i_val_q   <= 1'b0;
      d_val_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      aborted_q <= aborted_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_adr_q   <= m_adr_d;
      m_wdata_q <= m_wdata_d;
      d_rdata_q <= d_rdata_d;
      i_rdata_q <= i_rdata_d;
      i_val_q   <= i_val_d;
      d_val_q   <= d_val_d;
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_adr   = m_adr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.i_val   = i_val_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.d_val   = d_val_q;

`ifdef MEM_ARB_PERF_EN
  owner_e owner_q;
  logic   istall;

  // Remembers who owns the RESP cycle so a fetch awaiting its own pulse is not a stall.
  always_ff @(posedge clk) begin
    if (!reset)       owner_q <= OWN_I;
    else if (grant_i) owner_q <= OWN_I;
    else if (grant_d) owner_q <= OWN_D;
  end

  assign istall = bus.i_req &
                  ~((state_q == BUSY_I) | ((state_q == RESP) & (owner_q == OWN_I)));

  mem_arb_perf u_perf (
    .clk      (clk),
    .reset    (reset),
    .igrant_i (grant_i),
    .dgrant_i (grant_d),
    .istall_i (istall),
    .igrant_o (perf_igrant),
    .dgrant_o (perf_dgrant),
    .istall_o (perf_istall)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int N  = 64;
  localparam int SM = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arb_if #(.N(N)) bus ();

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_igrant, perf_dgrant, perf_istall;
`endif

  mem_arbiter #(.N(N), .STARVE_MAX(SM)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_igrant (perf_igrant),
    .perf_dgrant (perf_dgrant),
    .perf_istall (perf_istall)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: transaction lifecycle and the expected outputs for the next cycle.
  bit          md_free, md_wait, md_own_i, md_abt;
  int          md_starve;
  logic        e_mreq, e_ival, e_dval;
  logic [1:0]  e_mwe;
  logic [63:0] e_madr, e_mwdata, e_drdata;
  logic [31:0] e_irdata;

  // Environment state
  bit          i_pend, d_pend;
  int          ack_cnt = -1;
  int          ack_fix = 0;
  bit          rd_fix  = 1'b1;
  logic [63:0] rd_val  = 64'h1111_2222_3333_4444;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    md_free = 1'b1; md_wait = 1'b0; md_own_i = 1'b0; md_abt = 1'b0; md_starve = 0;
    e_mreq = 1'b0; e_ival = 1'b0; e_dval = 1'b0; e_mwe = 2'b00;
    e_madr = '0; e_mwdata = '0; e_drdata = '0; e_irdata = '0;
  endtask

  task automatic model_cycle();
    bit i_ok;
    bit start;
    start  = 1'b0;
    e_ival = 1'b0;
    e_dval = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (md_free) begin
      i_ok = bus.i_req && !bus.i_abort;
      if (bus.d_req && !(i_ok && md_starve >= SM)) begin
        if (bus.i_req && md_starve < SM) md_starve++;
        md_own_i = 1'b0;
        e_mwe    = (bus.d_we == 2'b00) ? 2'b00 : (bus.d_we == 2'b01) ? 2'b01 : 2'b11;
        e_madr   = bus.d_adr;
        e_mwdata = bus.d_wdata;
        start    = 1'b1;
      end else if (i_ok) begin
        md_starve = 0;
        md_own_i  = 1'b1;
        e_mwe     = 2'b00;
        e_madr    = {32'h0, bus.i_adr};
        e_mwdata  = '0;
        start     = 1'b1;
      end
      if (start) begin
        md_free = 1'b0; md_wait = 1'b1; md_abt = 1'b0; e_mreq = 1'b1;
      end
    end else if (md_wait) begin
      if (md_own_i && bus.i_abort) md_abt = 1'b1;
      if (bus.m_ack) begin
        md_wait = 1'b0;
        e_mreq  = 1'b0;
        if (md_own_i) begin
          if (!md_abt) begin
            e_ival   = 1'b1;
            e_irdata = e_madr[2] ? bus.m_rdata[63:32] : bus.m_rdata[31:0];
          end
        end else begin
          e_dval = 1'b1;
          if (e_mwe == 2'b00) e_drdata = bus.m_rdata;
        end
      end
    end else begin
      md_free = 1'b1;
    end
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    chk_eq("m_req",   64'(bus.m_req),   64'(e_mreq));
    chk_eq("m_we",    64'(bus.m_we),    64'(e_mwe));
    chk_eq("m_adr",   bus.m_adr,        e_madr);
    chk_eq("m_wdata", bus.m_wdata,      e_mwdata);
    chk_eq("i_val",   64'(bus.i_val),   64'(e_ival));
    chk_eq("d_val",   64'(bus.d_val),   64'(e_dval));
    chk_eq("i_rdata", 64'(bus.i_rdata), 64'(e_irdata));
    chk_eq("d_rdata", bus.d_rdata,      e_drdata);
  endtask

  task automatic idle_inputs();
    bus.i_req = 1'b0; bus.i_adr = '0; bus.i_abort = 1'b0;
    bus.d_req = 1'b0; bus.d_we = 2'b00; bus.d_adr = '0; bus.d_wdata = '0;
    bus.m_rdata = '0; bus.m_ack = 1'b0;
  endtask

  task automatic mem_drive();
    bus.m_rdata = rd_fix ? rd_val : {$urandom, $urandom};
    if (bus.m_req) begin
      if (ack_cnt < 0) ack_cnt = (ack_fix >= 0) ? ack_fix : int'($urandom_range(0, 3));
      if (ack_cnt == 0) begin
        bus.m_ack = 1'b1;
        ack_cnt   = -1;
      end else begin
        bus.m_ack = 1'b0;
        ack_cnt--;
      end
    end else begin
      ack_cnt   = -1;
      bus.m_ack = (ack_fix < 0) && ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic env_cycle();
    if (bus.i_val) i_pend = 1'b0;
    if (bus.d_val) d_pend = 1'b0;
    rst_n = ($urandom_range(0, 299) != 0);
    if (!rst_n) begin
      i_pend = 1'b0;
      d_pend = 1'b0;
    end
    bus.i_abort = 1'b0;
    if (i_pend && $urandom_range(0, 19) == 0) begin
      i_pend      = 1'b0;
      bus.i_abort = 1'b1;
    end else if (!i_pend && $urandom_range(0, 2) == 0) begin
      i_pend    = 1'b1;
      bus.i_adr = $urandom & 32'hFFFF_FFFC;
    end
    bus.i_req = i_pend;
    if (!d_pend && $urandom_range(0, 1) == 0) begin
      d_pend      = 1'b1;
      bus.d_we    = 2'($urandom_range(0, 3));
      bus.d_adr   = {$urandom, $urandom};
      bus.d_wdata = {$urandom, $urandom};
    end
    bus.d_req = d_pend;
    mem_drive();
  endtask

  initial begin
    bit got_i, got_d, i_first;
    int dcnt, nv;

    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) begin mem_drive(); step(); end
    rst_n = 1'b1;

    // Fetch alone, one-cycle ack: i_val on the third cycle, upper word selected.
    bus.i_req = 1'b1; bus.i_adr = 32'h4;
    mem_drive(); step();
    mem_drive(); step();
    chk_eq("ionly_val",  64'(bus.i_val),   64'd1);
    chk_eq("ionly_data", 64'(bus.i_rdata), 64'h1111_2222);
    bus.i_req = 1'b0;
    mem_drive(); step();

    // Simultaneous requests: data first, then fetch.
    bus.i_req = 1'b1; bus.i_adr = 32'h8;
    bus.d_req = 1'b1; bus.d_we = 2'b00; bus.d_adr = 64'h40;
    got_i = 1'b0; got_d = 1'b0; i_first = 1'b0;
    for (int k = 0; k < 20 && !(got_i && got_d); k++) begin
      mem_drive(); step();
      if (bus.i_val && !got_d) i_first = 1'b1;
      if (bus.d_val) begin got_d = 1'b1; bus.d_req = 1'b0; end
      if (bus.i_val) begin got_i = 1'b1; bus.i_req = 1'b0; end
    end
    chk_eq("coll_done",    64'(got_i && got_d), 64'd1);
    chk_eq("coll_i_first", 64'(i_first),        64'd0);

    // Continuous data traffic: fetch wins after exactly SM data grants.
    bus.d_req = 1'b1; bus.d_we = 2'b00; bus.d_adr = 64'h1000;
    bus.i_req = 1'b1; bus.i_adr = 32'h10;
    dcnt = 0; got_i = 1'b0;
    for (int k = 0; k < 60 && !got_i; k++) begin
      mem_drive(); step();
      if (bus.d_val) begin dcnt++; bus.d_adr = bus.d_adr + 64'd8; end
      if (bus.i_val) got_i = 1'b1;
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    chk_eq("starve_done",    64'(got_i), 64'd1);
    chk_eq("starve_dgrants", 64'(dcnt),  64'(SM));
    mem_drive(); step();

    // Abort during a slow fetch: no pulse, instruction register keeps the last fetch.
    ack_fix = 5;
    bus.i_req = 1'b1; bus.i_adr = 32'hC;
    for (int k = 0; k < 5 && !bus.m_req; k++) begin mem_drive(); step(); end
    chk_eq("abort_grant", 64'(bus.m_req), 64'd1);
    bus.i_abort = 1'b1; bus.i_req = 1'b0;
    mem_drive(); step();
    bus.i_abort = 1'b0;
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      mem_drive(); step();
      if (bus.i_val) nv++;
    end
    chk_eq("abort_noval",  64'(nv),          64'd0);
    chk_eq("abort_irdata", 64'(bus.i_rdata), 64'h3333_4444);
    ack_fix = 0;
    bus.d_req = 1'b1; bus.d_we = 2'b00; bus.d_adr = 64'h100;
    got_d = 1'b0;
    for (int k = 0; k < 10 && !got_d; k++) begin
      mem_drive(); step();
      if (bus.d_val) begin got_d = 1'b1; bus.d_req = 1'b0; end
    end
    chk_eq("abort_next", 64'(got_d), 64'd1);

    // 32-bit write: encoding forwarded, read-data register untouched.
    bus.d_req = 1'b1; bus.d_we = 2'b01; bus.d_adr = 64'h80; bus.d_wdata = 64'hDEAD_BEEF;
    for (int k = 0; k < 5 && !bus.m_req; k++) begin mem_drive(); step(); end
    chk_eq("wr_mwe",   64'(bus.m_we), 64'd1);
    chk_eq("wr_madr",  bus.m_adr,     64'h80);
    chk_eq("wr_wdata", bus.m_wdata,   64'hDEAD_BEEF);
    got_d = 1'b0;
    for (int k = 0; k < 5 && !got_d; k++) begin
      mem_drive(); step();
      if (bus.d_val) begin got_d = 1'b1; bus.d_req = 1'b0; end
    end
    chk_eq("wr_dval",   64'(got_d),  64'd1);
    chk_eq("wr_drdata", bus.d_rdata, 64'h1111_2222_3333_4444);

    // Reset while a data read is outstanding; the late ack must be ignored.
    ack_fix = 10;
    bus.d_req = 1'b1; bus.d_we = 2'b00; bus.d_adr = 64'h200;
    for (int k = 0; k < 5 && !bus.m_req; k++) begin mem_drive(); step(); end
    chk_eq("rst_busy", 64'(bus.m_req), 64'd1);
    rst_n = 1'b0; bus.d_req = 1'b0;
    mem_drive(); step();
    chk_eq("rst_mreq", 64'(bus.m_req), 64'd0);
    rst_n = 1'b1;
    mem_drive(); bus.m_ack = 1'b1;
    step();
    nv = 0;
    for (int k = 0; k < 4; k++) begin
      mem_drive(); step();
      if (bus.d_val) nv++;
    end
    chk_eq("rst_noval", 64'(nv), 64'd0);

    // Randomized traffic with random ack latency, spurious acks and occasional resets.
    ack_fix = -1; rd_fix = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0;
    idle_inputs();
    repeat (2000) begin env_cycle(); step(); end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
